// File: rtl/crash_detector_pkg.sv
// Shared playfield constants and crash/miss bit positions for the ball datapath.
// The ball mover imports the same CRASH_* indices to decode oCrash.
package crash_detector_pkg;

  localparam int X_MIN      = 8;
  localparam int X_MAX      = 632;
  localparam int Y_MIN      = 8;
  localparam int Y_MAX      = 472;
  localparam int BALL_SIZE  = 16;
  localparam int PADDLE_LEN = 64;
  localparam int WIN_SCORE  = 9;

  localparam int CRASH_LEFT  = 3;
  localparam int CRASH_RIGHT = 2;
  localparam int CRASH_UP    = 1;
  localparam int CRASH_DOWN  = 0;

  localparam int MISS_LEFT  = 1;
  localparam int MISS_RIGHT = 0;

  // Coordinates are widened to 11 bits before adding sizes so sums never wrap.
  function automatic logic [10:0] widen(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/crash_detector_arm.sv
// One-shot pulse generator: emits a single registered pulse per zone entry and
// re-arms only after the zone condition has dropped for at least one cycle.
module crash_arm (
  input  logic iVGA_CLK,
  input  logic iRST_n,
  input  logic zone_i,
  output logic fire_o,
  output logic pulse_o
);

  logic armed_q, armed_d;
  logic pulse_q, pulse_d;

  // fire_o is the unregistered request so the top can qualify misses in the same cycle.
  always_comb begin
    fire_o  = zone_i & armed_q;
    pulse_d = fire_o;
    armed_d = ~zone_i;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      armed_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/crash_detector.sv
// Wall/paddle collision detector feeding the ball mover and score overlay.
// Paddle checks, misses and scoring exist only when CRASH_PADDLE_EN is defined.
module crash_detector
  import crash_detector_pkg::*;
#(
  parameter int X_MIN      = crash_detector_pkg::X_MIN,
  parameter int X_MAX      = crash_detector_pkg::X_MAX,
  parameter int Y_MIN      = crash_detector_pkg::Y_MIN,
  parameter int Y_MAX      = crash_detector_pkg::Y_MAX,
  parameter int BALL_SIZE  = crash_detector_pkg::BALL_SIZE,
  parameter int PADDLE_LEN = crash_detector_pkg::PADDLE_LEN,
  parameter int WIN_SCORE  = crash_detector_pkg::WIN_SCORE
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [9:0] iBall_x,
  input  logic [9:0] iBall_y,
  input  logic [9:0] iPaddleL_y,
  input  logic [9:0] iPaddleR_y,
  output logic [3:0] oCrash,
  output logic [1:0] oMiss,
  output logic [3:0] oScoreL,
  output logic [3:0] oScoreR,
  output logic       oGameOver
);

  localparam logic [10:0] X_MIN_W = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_W = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);
  localparam logic [10:0] BALL_W  = 11'(BALL_SIZE);

  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic [3:0]  zone;
  logic [3:0]  fire;

  always_comb begin
    ball_x = widen(iBall_x);
    ball_y = widen(iBall_y);
    zone   = '0;
    zone[CRASH_LEFT]  = (ball_x <= X_MIN_W);
    zone[CRASH_RIGHT] = (ball_x + BALL_W >= X_MAX_W);
    zone[CRASH_UP]    = (ball_y <= Y_MIN_W);
    zone[CRASH_DOWN]  = (ball_y + BALL_W >= Y_MAX_W);
  end

  for (genvar i = 0; i < 4; i++) begin : g_arm
    crash_arm u_arm (
      .iVGA_CLK (iVGA_CLK),
      .iRST_n   (iRST_n),
      .zone_i   (zone[i]),
      .fire_o   (fire[i]),
      .pulse_o  (oCrash[i])
    );
  end

`ifdef CRASH_PADDLE_EN
  localparam logic [10:0] PADDLE_W = 11'(PADDLE_LEN);
  localparam logic [3:0]  WIN_W    = 4'(WIN_SCORE);

  logic       overlap_l, overlap_r;
  logic [1:0] miss_q, miss_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       game_over_q, game_over_d;

  // A side crash always bounces; it only counts as a miss when the paddle is elsewhere.
  // Scores freeze once the game is over, but crashes and misses keep flowing.
  always_comb begin
    overlap_l = (ball_y + BALL_W > widen(iPaddleL_y)) &&
                (ball_y < widen(iPaddleL_y) + PADDLE_W);
    overlap_r = (ball_y + BALL_W > widen(iPaddleR_y)) &&
                (ball_y < widen(iPaddleR_y) + PADDLE_W);
    miss_d = '0;
    miss_d[MISS_LEFT]  = fire[CRASH_LEFT]  & ~overlap_l;
    miss_d[MISS_RIGHT] = fire[CRASH_RIGHT] & ~overlap_r;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    if (!game_over_q) begin
      if (miss_d[MISS_RIGHT] && (score_l_q < WIN_W)) score_l_d = score_l_q + 4'd1;
      if (miss_d[MISS_LEFT]  && (score_r_q < WIN_W)) score_r_d = score_r_q + 4'd1;
    end
    game_over_d = game_over_q | (score_l_d == WIN_W) | (score_r_d == WIN_W);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      miss_q      <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      game_over_q <= 1'b0;
    end else begin
      miss_q      <= miss_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      game_over_q <= game_over_d;
    end
  end

  assign oMiss     = miss_q;
  assign oScoreL   = score_l_q;
  assign oScoreR   = score_r_q;
  assign oGameOver = game_over_q;
`else
  localparam int unused_params = PADDLE_LEN + WIN_SCORE;
  logic unused_paddle;

  assign unused_paddle = ^{iPaddleL_y, iPaddleR_y};
  assign oMiss     = 2'b00;
  assign oScoreL   = 4'd0;
  assign oScoreR   = 4'd0;
  assign oGameOver = 1'b0;
`endif

endmodule

// File: tb/tb_crash_detector.sv
// Directed bench for crash_detector; expectations adapt to CRASH_PADDLE_EN.
module tb_crash_detector;

`ifdef CRASH_PADDLE_EN
  localparam bit PADDLE = 1'b1;
`else
  localparam bit PADDLE = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [9:0] ball_x, ball_y, paddle_l, paddle_r;
  logic [3:0] crash;
  logic [1:0] miss;
  logic [3:0] score_l, score_r;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  crash_detector dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .iBall_x    (ball_x),
    .iBall_y    (ball_y),
    .iPaddleL_y (paddle_l),
    .iPaddleR_y (paddle_r),
    .oCrash     (crash),
    .oMiss      (miss),
    .oScoreL    (score_l),
    .oScoreR    (score_r),
    .oGameOver  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [9:0] x, input logic [9:0] y);
    ball_x = x;
    ball_y = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    ball_x   = 10'd300;
    ball_y   = 10'd200;
    paddle_l = 10'd180;
    paddle_r = 10'd180;
    #12;
    total++; if (crash !== 4'b0000) begin bad++; $display("[TB] FAIL reset_crash got=%b exp=%b", crash, 4'b0000); end
    total++; if (miss !== 2'b00) begin bad++; $display("[TB] FAIL reset_miss got=%b exp=%b", miss, 2'b00); end
    total++; if (score_l !== 4'd0) begin bad++; $display("[TB] FAIL reset_score_l got=%0d exp=0", score_l); end
    total++; if (score_r !== 4'd0) begin bad++; $display("[TB] FAIL reset_score_r got=%0d exp=0", score_r); end
    total++; if (game_over !== 1'b0) begin bad++; $display("[TB] FAIL reset_game_over got=%b exp=0", game_over); end
    rst_n = 1'b1;
    step(10'd300, 10'd200);
    total++; if (crash !== 4'b0000) begin bad++; $display("[TB] FAIL idle_crash got=%b exp=%b", crash, 4'b0000); end
  endtask

  task automatic test_left_approach();
    logic [3:0] exp_crash;
    paddle_l = 10'd180;
    for (int x = 20; x >= 6; x -= 2) begin
      step(10'(x), 10'd200);
      exp_crash = (x == 8) ? 4'b1000 : 4'b0000;
      total++; if (crash !== exp_crash) begin bad++; $display("[TB] FAIL approach_crash x=%0d got=%b exp=%b", x, crash, exp_crash); end
      total++; if (miss !== 2'b00) begin bad++; $display("[TB] FAIL approach_miss x=%0d got=%b exp=%b", x, miss, 2'b00); end
    end
  endtask

  task automatic test_hold();
    logic [3:0] exp_crash;
    step(10'd20, 10'd200);
    for (int i = 0; i < 10; i++) begin
      step(10'd4, 10'd200);
      exp_crash = (i == 0) ? 4'b1000 : 4'b0000;
      total++; if (crash !== exp_crash) begin bad++; $display("[TB] FAIL hold_crash cyc=%0d got=%b exp=%b", i, crash, exp_crash); end
    end
    step(10'd20, 10'd200);
    total++; if (crash !== 4'b0000) begin bad++; $display("[TB] FAIL hold_leave got=%b exp=%b", crash, 4'b0000); end
    step(10'd4, 10'd200);
    total++; if (crash !== 4'b1000) begin bad++; $display("[TB] FAIL hold_reentry got=%b exp=%b", crash, 4'b1000); end
  endtask

  task automatic test_miss();
    logic [1:0] exp_miss;
    logic [3:0] exp_sr;
    exp_miss = PADDLE ? 2'b10 : 2'b00;
    exp_sr   = PADDLE ? 4'd1 : 4'd0;
    paddle_l = 10'd100;
    step(10'd20, 10'd300);
    total++; if (crash !== 4'b0000) begin bad++; $display("[TB] FAIL miss_pre got=%b exp=%b", crash, 4'b0000); end
    step(10'd8, 10'd300);
    total++; if (crash !== 4'b1000) begin bad++; $display("[TB] FAIL miss_crash got=%b exp=%b", crash, 4'b1000); end
    total++; if (miss !== exp_miss) begin bad++; $display("[TB] FAIL miss_pulse got=%b exp=%b", miss, exp_miss); end
    total++; if (score_r !== exp_sr) begin bad++; $display("[TB] FAIL miss_score_r got=%0d exp=%0d", score_r, exp_sr); end
    total++; if (score_l !== 4'd0) begin bad++; $display("[TB] FAIL miss_score_l got=%0d exp=0", score_l); end
    step(10'd8, 10'd300);
    total++; if (crash !== 4'b0000) begin bad++; $display("[TB] FAIL miss_after_crash got=%b exp=%b", crash, 4'b0000); end
    total++; if (miss !== 2'b00) begin bad++; $display("[TB] FAIL miss_after_pulse got=%b exp=%b", miss, 2'b00); end
    total++; if (score_r !== exp_sr) begin bad++; $display("[TB] FAIL miss_score_hold got=%0d exp=%0d", score_r, exp_sr); end
  endtask

  task automatic test_corner();
    paddle_l = 10'd0;
    step(10'd20, 10'd200);
    total++; if (crash !== 4'b0000) begin bad++; $display("[TB] FAIL corner_pre got=%b exp=%b", crash, 4'b0000); end
    step(10'd8, 10'd8);
    total++; if (crash !== 4'b1010) begin bad++; $display("[TB] FAIL corner_crash got=%b exp=%b", crash, 4'b1010); end
    total++; if (miss !== 2'b00) begin bad++; $display("[TB] FAIL corner_miss got=%b exp=%b", miss, 2'b00); end
    step(10'd8, 10'd8);
    total++; if (crash !== 4'b0000) begin bad++; $display("[TB] FAIL corner_once got=%b exp=%b", crash, 4'b0000); end
  endtask

  task automatic test_walls();
    paddle_r = 10'd440;
    step(10'd300, 10'd200);
    step(10'd9, 10'd9);
    total++; if (crash !== 4'b0000) begin bad++; $display("[TB] FAIL walls_inside_lu got=%b exp=%b", crash, 4'b0000); end
    step(10'd615, 10'd455);
    total++; if (crash !== 4'b0000) begin bad++; $display("[TB] FAIL walls_inside_rd got=%b exp=%b", crash, 4'b0000); end
    step(10'd616, 10'd456);
    total++; if (crash !== 4'b0101) begin bad++; $display("[TB] FAIL walls_rd got=%b exp=%b", crash, 4'b0101); end
    total++; if (miss !== 2'b00) begin bad++; $display("[TB] FAIL walls_rd_miss got=%b exp=%b", miss, 2'b00); end
  endtask

  task automatic test_score();
    logic [3:0] exp_sl;
    logic [3:0] exp_sr;
    logic       exp_go;
    logic [1:0] exp_miss;
    exp_sl   = 4'd0;
    exp_sr   = PADDLE ? 4'd1 : 4'd0;
    exp_miss = PADDLE ? 2'b01 : 2'b00;
    paddle_r = 10'd400;
    for (int i = 0; i < 10; i++) begin
      step(10'd300, 10'd200);
      step(10'd616, 10'd200);
      if (PADDLE && exp_sl < 4'd9) exp_sl = exp_sl + 4'd1;
      exp_go = (exp_sl == 4'd9);
      total++; if (crash !== 4'b0100) begin bad++; $display("[TB] FAIL score_crash n=%0d got=%b exp=%b", i, crash, 4'b0100); end
      total++; if (miss !== exp_miss) begin bad++; $display("[TB] FAIL score_miss n=%0d got=%b exp=%b", i, miss, exp_miss); end
      total++; if (score_l !== exp_sl) begin bad++; $display("[TB] FAIL score_l n=%0d got=%0d exp=%0d", i, score_l, exp_sl); end
      total++; if (score_r !== exp_sr) begin bad++; $display("[TB] FAIL score_r n=%0d got=%0d exp=%0d", i, score_r, exp_sr); end
      total++; if (game_over !== exp_go) begin bad++; $display("[TB] FAIL score_game_over n=%0d got=%b exp=%b", i, game_over, exp_go); end
    end
  endtask

  task automatic test_reset_mid();
    step(10'd300, 10'd200);
    step(10'd616, 10'd200);
    total++; if (crash !== 4'b0100) begin bad++; $display("[TB] FAIL midrst_pulse got=%b exp=%b", crash, 4'b0100); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (crash !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_crash got=%b exp=%b", crash, 4'b0000); end
    total++; if (miss !== 2'b00) begin bad++; $display("[TB] FAIL midrst_miss got=%b exp=%b", miss, 2'b00); end
    total++; if (score_l !== 4'd0) begin bad++; $display("[TB] FAIL midrst_score_l got=%0d exp=0", score_l); end
    total++; if (score_r !== 4'd0) begin bad++; $display("[TB] FAIL midrst_score_r got=%0d exp=0", score_r); end
    total++; if (game_over !== 1'b0) begin bad++; $display("[TB] FAIL midrst_game_over got=%b exp=0", game_over); end
    ball_x = 10'd300;
    ball_y = 10'd460;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++; if (crash !== 4'b0001) begin bad++; $display("[TB] FAIL midrst_first_down got=%b exp=%b", crash, 4'b0001); end
    step(10'd300, 10'd460);
    total++; if (crash !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_down_once got=%b exp=%b", crash, 4'b0000); end
  endtask

  initial begin
    test_reset();
    test_left_approach();
    test_hold();
    test_miss();
    test_corner();
    test_walls();
    test_score();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
